// File: rtl/led_matrix_dim_if.sv
// Write/swap handshake between the pattern logic and the LED matrix driver.
interface led_matrix_dim_if #(
    parameter int ADDR_W = 4,
    parameter int BW     = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BW-1:0]     wr_data;
    logic              wr_ready;
    logic              swap;
    logic              swap_pending;

    modport master (output wr_en, wr_addr, wr_data, swap, input wr_ready, swap_pending);
    modport slave  (input wr_en, wr_addr, wr_data, swap, output wr_ready, swap_pending);
endinterface

// File: rtl/led_matrix_dim.sv
// Row-scanned LED matrix driver with per-LED PWM, row blanking and a double-buffered frame store.
// Optional global dimming input enabled by defining LEDM_GLOBAL_DIM_EN.
module led_matrix_dim #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int BW           = 4,
    parameter int TICK_DIV     = 2,
    parameter int BLANK_CYCLES = 3,
    parameter int ADDR_W       = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    led_matrix_dim_if.slave  bus,
`ifdef LEDM_GLOBAL_DIM_EN
    input  logic [BW-1:0]    dim,
`endif
    output logic             frame_start,
    output logic [ROWS-1:0]  aled,
    output logic [COLS-1:0]  kled_tri
);
    localparam int NLED = ROWS * COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(BLANK_CYCLES + TICK_DIV + 1);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_PWM   = 1'b1;

    localparam logic [BW-1:0] TICK_LAST  = BW'((1 << BW) - 2);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(TICK_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    logic [BW-1:0]   fb [2][NLED];
    logic            front_sel;
    logic            pend_q;
    logic            ready_q;
    logic            run;

    logic [0:0]      st,   st_n;
    logic [RW-1:0]   row,  row_n;
    logic [CW-1:0]   cnt,  cnt_n;
    logic [BW-1:0]   tick, tick_n;

    logic            boundary;
    logic            row_entry;
    logic            wr_ok;
    logic [COLS-1:0] kled_n;
    logic [BW-1:0]   dim_q;

    assign bus.swap_pending = pend_q;
    assign bus.wr_ready     = ready_q;

    // Outputs are registered from the next scan position, so the registered
    // position always matches what is visible on the pins.
    always_comb begin
        st_n   = st;
        row_n  = row;
        cnt_n  = cnt + 1'b1;
        tick_n = tick;
        if (!run) begin
            st_n   = S_BLANK;
            row_n  = '0;
            cnt_n  = '0;
            tick_n = '0;
        end else if (st == S_BLANK) begin
            if (cnt == BLANK_LAST) begin
                st_n   = S_PWM;
                cnt_n  = '0;
                tick_n = '0;
            end
        end else if (cnt == DIV_LAST) begin
            cnt_n = '0;
            if (tick == TICK_LAST) begin
                st_n   = S_BLANK;
                tick_n = '0;
                row_n  = (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                tick_n = tick + 1'b1;
            end
        end
    end

    assign row_entry = (st_n == S_BLANK) && (cnt_n == '0);
    assign boundary  = row_entry && (row_n == '0);
    assign wr_ok     = bus.wr_en && ready_q && (int'(bus.wr_addr) < NLED);

    always_comb begin
        kled_n = '0;
        for (int c = 0; c < COLS; c++) begin
            kled_n[c] = (st_n == S_PWM)
                      && (fb[front_sel][ADDR_W'(int'(row_n) * COLS + c)] > tick_n)
                      && (dim_q > tick_n);
        end
    end

`ifdef LEDM_GLOBAL_DIM_EN
    // Dim is latched once per row so a change never glitches a lit row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q <= '1;
        end else if (row_entry) begin
            dim_q <= dim;
        end
    end
`else
    assign dim_q = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            st          <= S_BLANK;
            row         <= '0;
            cnt         <= '0;
            tick        <= '0;
            aled        <= '0;
            kled_tri    <= '0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            st          <= st_n;
            row         <= row_n;
            cnt         <= cnt_n;
            tick        <= tick_n;
            aled        <= (st_n == S_PWM) ? (ROWS'(1) << row_n) : '0;
            kled_tri    <= kled_n;
            frame_start <= boundary;
        end
    end

    // Commit and request are exclusive: commit needs pending, request needs idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b1;
            for (int i = 0; i < NLED; i++) begin
                fb[0][i] <= '0;
                fb[1][i] <= '0;
            end
        end else begin
            if (pend_q && boundary) begin
                front_sel <= ~front_sel;
                pend_q    <= 1'b0;
                ready_q   <= 1'b1;
            end else if (!pend_q && bus.swap) begin
                pend_q    <= 1'b1;
                ready_q   <= 1'b0;
            end
            if (wr_ok) begin
                fb[~front_sel][bus.wr_addr] <= bus.wr_data;
            end
        end
    end
endmodule
